// File: rtl/crypto_fe_pkg.sv
// ============================================================================
// crypto_fe_pkg : register map, bit indices and FSM states for the crypto WB front-end
// Rev 1.0
// ============================================================================
`default_nettype none

package crypto_fe_pkg;

    localparam int BLOCK_W = 128;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_DIN0   = 8'h10;
    localparam logic [7:0] OFF_DIN3   = 8'h1C;
    localparam logic [7:0] OFF_DOUT0  = 8'h20;
    localparam logic [7:0] OFF_DOUT1  = 8'h24;
    localparam logic [7:0] OFF_DOUT2  = 8'h28;
    localparam logic [7:0] OFF_DOUT3  = 8'h2C;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_MODE    = 2;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fe_state_t;

endpackage

`default_nettype wire

// File: rtl/crypto_fe_watchdog.sv
// ============================================================================
// crypto_fe_watchdog : counts cycles spent waiting for the core, flags expiry at LIMIT
// Rev 1.0
// ============================================================================
`default_nettype none

module crypto_fe_watchdog #(
    parameter logic [15:0] LIMIT = 16'd1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 16'd0;
        end else if (clear_i) begin
            cnt_q <= 16'd0;
        end else if (run_i) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // Fires on the LIMIT-th waiting cycle, so the wait lasts exactly LIMIT cycles
    assign expired_o = run_i && ((cnt_q + 16'd1) == LIMIT);

endmodule

`default_nettype wire

// File: rtl/crypto_wb_frontend.sv
// ============================================================================
// crypto_wb_frontend : Wishbone register front-end feeding 128-bit blocks to the crypto core
// Define CRYPTO_FE_TIMEOUT_EN to add the WAIT-state watchdog. Rev 1.0
// ============================================================================
`default_nettype none

module crypto_wb_frontend
    import crypto_fe_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [BLOCK_W-1:0] core_din_o,
    output logic               core_mode_o,
    output logic               core_valid_o,
    input  logic               core_ready_i,
    input  logic               core_done_i,
    input  logic [BLOCK_W-1:0] core_dout_i,
    output logic               irq_o
);

    logic               ack_q;
    logic [31:0]        dat_q;
    logic [3:0][31:0]   din_q;
    logic               irq_en_q;
    logic               mode_q;
    fe_state_t          state_q;
    logic               valid_q;
    logic [BLOCK_W-1:0] core_din_q;
    logic               core_mode_q;
    logic [BLOCK_W-1:0] dout_q;
    logic               done_q;
    logic               timeout_q;

    logic        w_req;
    logic        w_in_win;
    logic [7:0]  w_off;
    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_start_wr;
    logic        w_status_wr;
    logic        w_din_wr;
    logic        w_busy;
    logic        w_expired;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign w_in_win    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_off       = {wbs_adr_i[7:2], 2'b00};
    assign w_wr        = w_req & wbs_we_i & w_in_win;
    assign w_ctrl_wr   = w_wr & (w_off == OFF_CTRL) & wbs_sel_i[0];
    assign w_start_wr  = w_ctrl_wr & wbs_dat_i[CTRL_START];
    assign w_status_wr = w_wr & (w_off == OFF_STATUS);
    assign w_din_wr    = w_wr & (w_off >= OFF_DIN0) & (w_off <= OFF_DIN3);
    assign w_busy      = (state_q != IDLE);

    always_comb begin
        w_rdata = 32'd0;
        if (w_in_win) begin
            case (w_off)
                OFF_CTRL:   w_rdata = {29'd0, mode_q, irq_en_q, 1'b0};
                OFF_STATUS: w_rdata = {29'd0, timeout_q, done_q, w_busy};
                OFF_DOUT0:  w_rdata = dout_q[31:0];
                OFF_DOUT1:  w_rdata = dout_q[63:32];
                OFF_DOUT2:  w_rdata = dout_q[95:64];
                OFF_DOUT3:  w_rdata = dout_q[127:96];
                default: begin
                    if ((w_off >= OFF_DIN0) && (w_off <= OFF_DIN3)) begin
                        w_rdata = din_q[w_off[3:2]];
                    end
                end
            endcase
        end
    end

    // Bus side: ack/read data plus the software-owned RW registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            din_q    <= '0;
            irq_en_q <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            ack_q <= w_req;
            dat_q <= (w_req & ~wbs_we_i) ? w_rdata : 32'd0;
            if (w_ctrl_wr) begin
                irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
                mode_q   <= wbs_dat_i[CTRL_MODE];
            end
            if (w_din_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) begin
                        din_q[w_off[3:2]][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // Core side FSM; W1C is applied before the set so a same-cycle completion wins
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            core_din_q  <= '0;
            core_mode_q <= 1'b0;
            dout_q      <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (w_status_wr) begin
                if (wbs_dat_i[STAT_DONE])    done_q    <= 1'b0;
                if (wbs_dat_i[STAT_TIMEOUT]) timeout_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (w_start_wr) begin
                        state_q     <= ISSUE;
                        valid_q     <= 1'b1;
                        core_din_q  <= din_q;
                        core_mode_q <= wbs_dat_i[CTRL_MODE];
                    end
                end
                ISSUE: begin
                    if (core_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_done_i) begin
                        dout_q  <= core_dout_i;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (w_expired) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CRYPTO_FE_TIMEOUT_EN
    crypto_fe_watchdog #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (wb_clk_i),
        .rst_n_i   (wb_rst_n_i),
        .clear_i   ((state_q == ISSUE) && core_ready_i),
        .run_i     (state_q == WAIT),
        .expired_o (w_expired)
    );
    assign w_unused = ^wbs_adr_i[1:0];
`else
    assign w_expired = 1'b0;
    assign w_unused  = ^{wbs_adr_i[1:0], TIMEOUT_CYCLES};
`endif

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign core_din_o   = core_din_q;
    assign core_mode_o  = core_mode_q;
    assign core_valid_o = valid_q;
    assign irq_o        = done_q & irq_en_q;

endmodule

`default_nettype wire

// File: tb/tb_crypto_wb_frontend.sv
// ============================================================================
// tb_crypto_wb_frontend : directed bench with a register-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_crypto_wb_frontend;

    localparam logic [31:0]  BASE    = 32'h3000_0000;
    localparam logic [23:0]  BASE_HI = 24'h300000;
    localparam logic [15:0]  TO      = 16'd8;
`ifdef CRYPTO_FE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [31:0]  adr = 32'd0, wdat = 32'd0;
    logic         ack;
    logic [31:0]  rdat;
    logic [127:0] core_din;
    logic         core_mode, core_valid, irq;
    logic         ready = 1'b0, done_in = 1'b0;
    logic [127:0] dout_in = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    crypto_wb_frontend #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .core_din_o   (core_din),
        .core_mode_o  (core_mode),
        .core_valid_o (core_valid),
        .core_ready_i (ready),
        .core_done_i  (done_in),
        .core_dout_i  (dout_in),
        .irq_o        (irq)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (register-level view) ----------------
    logic [31:0]  m_din [4];
    logic         m_irq_en, m_mode, m_done, m_timeout;
    logic [127:0] m_dout, m_core_din;
    logic         m_core_mode;
    logic         m_valid, m_wait;
    int           m_wcnt;
    logic         m_ack, m_rd_valid;
    logic [31:0]  m_rd;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_din[i] = 32'd0;
        m_irq_en = 0; m_mode = 0; m_done = 0; m_timeout = 0;
        m_dout = '0; m_core_din = '0; m_core_mode = 0;
        m_valid = 0; m_wait = 0; m_wcnt = 0;
        m_ack = 0; m_rd_valid = 0; m_rd = 32'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic busy;
        busy = m_valid | m_wait;
        if (a[31:8] != BASE_HI) return 32'd0;
        case (a[7:0])
            8'h00: return {29'd0, m_mode, m_irq_en, 1'b0};
            8'h04: return {29'd0, m_timeout, m_done, busy};
            8'h10: return m_din[0];
            8'h14: return m_din[1];
            8'h18: return m_din[2];
            8'h1C: return m_din[3];
            8'h20: return m_dout[31:0];
            8'h24: return m_dout[63:32];
            8'h28: return m_dout[95:64];
            8'h2C: return m_dout[127:96];
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        if (a[31:8] != BASE_HI) return;
        case (a[7:0])
            8'h00: if (s[0]) begin
                m_irq_en = d[1];
                m_mode   = d[2];
                if (d[0] && !(m_valid || m_wait)) begin
                    m_valid     = 1;
                    m_core_din  = {m_din[3], m_din[2], m_din[1], m_din[0]};
                    m_core_mode = d[2];
                end
            end
            8'h04: begin
                if (d[1]) m_done = 0;
                if (d[2]) m_timeout = 0;
            end
            8'h10, 8'h14, 8'h18, 8'h1C: begin
                k = int'(a[3:2]);
                for (int b = 0; b < 4; b++)
                    if (s[b]) m_din[k][8*b +: 8] = d[8*b +: 8];
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_step
        bit req, was_issue, was_wait;
        if (!rst_n) begin
            model_reset();
        end else begin
            req       = cyc && stb && !m_ack;
            was_issue = m_valid;
            was_wait  = m_wait;
            m_ack      = req;
            m_rd_valid = req && !we;
            m_rd       = model_read(adr);
            if (req && we) model_write(adr, wdat, sel);
            if (was_wait) begin
                if (done_in) begin
                    m_dout = dout_in; m_done = 1; m_wait = 0;
                end else if (TO_EN && (m_wcnt + 1 == int'(TO))) begin
                    m_timeout = 1; m_done = 1; m_wait = 0;
                end else begin
                    m_wcnt++;
                end
            end
            if (was_issue && ready) begin
                m_valid = 0; m_wait = 1; m_wcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("ack", 128'(ack), 128'(m_ack));
        if (m_ack && m_rd_valid) chk("rdata", 128'(rdat), 128'(m_rd));
        chk("core_valid", 128'(core_valid), 128'(m_valid));
        chk("core_din", core_din, m_core_din);
        chk("core_mode", 128'(core_mode), 128'(m_core_mode));
        chk("irq", 128'(irq), 128'(m_done & m_irq_en));
    end

    // ---------------- stimulus helpers ----------------
    task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit with_done, input logic [127:0] dv, output logic [31:0] rd);
        int lat;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        if (with_done) begin done_in = 1; dout_in = dv; end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            done_in = 0;
        end while (!ack && lat < 8);
        if (!ack) begin
            n_cmp++; n_err++;
            $display("FAIL wb_ack_timeout: no ack for adr %h within 8 cycles", a);
        end else begin
            chk("ack_latency", 128'(lat), 128'd1);
        end
        rd = rdat;
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] x;
        wb_xfer(1'b1, a, d, 4'hF, 1'b0, '0, x);
    endtask

    task automatic wrs(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] x;
        wb_xfer(1'b1, a, d, s, 1'b0, '0, x);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        wb_xfer(1'b0, a, 32'd0, 4'hF, 1'b0, '0, v);
    endtask

    task automatic accept(input int stall);
        repeat (stall) @(posedge clk);
        @(negedge clk); ready = 1;
        @(posedge clk); #1; ready = 0;
    endtask

    task automatic pulse_done(input logic [127:0] v);
        @(negedge clk); done_in = 1; dout_in = v;
        @(posedge clk); #1; done_in = 0;
    endtask

    localparam logic [127:0] R1 = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
    localparam logic [127:0] R2 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] R3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] R4 = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;
    localparam logic [127:0] R5 = 128'h02468ACE_13579BDF_FEDCBA98_13579BDF;

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [31:0] v;
        logic [7:0]  offs [10];
        offs = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C};

        // 1. reset values and read-back of every register
        repeat (3) @(negedge clk);
        chk("rst_ack", 128'(ack), 128'd0);
        chk("rst_dat", 128'(rdat), 128'd0);
        chk("rst_valid", 128'(core_valid), 128'd0);
        chk("rst_irq", 128'(irq), 128'd0);
        chk("rst_core_din", core_din, 128'd0);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            rd(BASE + {24'd0, offs[i]}, v);
            chk("rst_read", 128'(v), 128'd0);
        end

        // 2. load block and start with irq enabled; core stalls 3 cycles
        wr(BASE + 32'h10, 32'h00112233);
        wr(BASE + 32'h14, 32'h44556677);
        wr(BASE + 32'h18, 32'h8899AABB);
        wr(BASE + 32'h1C, 32'hCCDDEEFF);
        wr(BASE + 32'h00, 32'h3);
        chk("blk1_din", core_din, 128'hCCDDEEFF_8899AABB_44556677_00112233);
        chk("blk1_valid", 128'(core_valid), 128'd1);
        accept(3);
        chk("blk1_valid_drop", 128'(core_valid), 128'd0);

        // 3. completion, result read-back, W1C of done
        pulse_done(R1);
        rd(BASE + 32'h20, v); chk("dout0", 128'(v), 128'h70B4C55A);
        rd(BASE + 32'h2C, v); chk("dout3", 128'(v), 128'h69C4E0D8);
        rd(BASE + 32'h04, v); chk("status_done", 128'(v), 128'h2);
        chk("irq_set", 128'(irq), 128'd1);
        wr(BASE + 32'h04, 32'h2);
        rd(BASE + 32'h04, v); chk("status_clr", 128'(v), 128'h0);
        chk("irq_clr", 128'(irq), 128'd0);

        // 4. start and DIN writes while busy; DOUT read racing the latch
        wr(BASE + 32'h00, 32'h3);
        accept(0);
        wr(BASE + 32'h00, 32'h3);
        wr(BASE + 32'h10, 32'h0BADF00D);
        rd(BASE + 32'h10, v); chk("din0_busy_wr", 128'(v), 128'h0BADF00D);
        chk("frozen_din", core_din, 128'hCCDDEEFF_8899AABB_44556677_00112233);
        wb_xfer(1'b0, BASE + 32'h20, 32'd0, 4'hF, 1'b1, R2, v);
        chk("dout_race_old", 128'(v), 128'h70B4C55A);
        rd(BASE + 32'h20, v); chk("dout_new", 128'(v), 128'h77778888);

        // start with done still set, then W1C colliding with completion
        wr(BASE + 32'h00, 32'h3);
        rd(BASE + 32'h04, v); chk("status_busy_done", 128'(v), 128'h3);
        accept(1);
        wb_xfer(1'b1, BASE + 32'h04, 32'h2, 4'hF, 1'b1, R3, v);
        rd(BASE + 32'h04, v); chk("done_set_wins", 128'(v), 128'h2);
        rd(BASE + 32'h20, v); chk("dout_r3", 128'(v), 128'hF0F0F0F0);
        wr(BASE + 32'h04, 32'h2);

        // done outside WAIT is ignored
        pulse_done(R4);
        rd(BASE + 32'h20, v); chk("done_idle_ignored", 128'(v), 128'hF0F0F0F0);

        // byte lanes on DIN and CTRL
        wrs(BASE + 32'h14, 32'hAABBCCDD, 4'b0101);
        rd(BASE + 32'h14, v); chk("din1_sel", 128'(v), 128'h44BB66DD);
        wrs(BASE + 32'h00, 32'h7, 4'b1110);
        rd(BASE + 32'h00, v); chk("ctrl_sel0_off", 128'(v), 128'h2);
        rd(BASE + 32'h04, v); chk("no_start_sel0", 128'(v), 128'h0);
        wr(BASE + 32'h00, 32'h6);
        rd(BASE + 32'h00, v); chk("ctrl_mode", 128'(v), 128'h6);

        // 5. unmapped and out-of-window accesses
        rd(BASE + 32'h40, v);  chk("unmapped_rd", 128'(v), 128'h0);
        rd(BASE + 32'h110, v); chk("outside_rd", 128'(v), 128'h0);
        wr(BASE + 32'h40, 32'hFFFFFFFF);
        wr(BASE + 32'h110, 32'h12345678);
        rd(BASE + 32'h10, v);  chk("din0_untouched", 128'(v), 128'h0BADF00D);
        rd(BASE + 32'h00, v);  chk("ctrl_untouched", 128'(v), 128'h6);

        // 6. decrypt-mode block with no completion from the core
        wr(BASE + 32'h00, 32'h7);
        chk("blk_mode", 128'(core_mode), 128'd1);
        chk("blk_din", core_din, 128'hCCDDEEFF_8899AABB_44BB66DD_0BADF00D);
        accept(0);
`ifdef CRYPTO_FE_TIMEOUT_EN
        repeat (7) @(posedge clk);
        #1 chk("to_not_yet", 128'(irq), 128'd0);
        @(posedge clk);
        #1 chk("to_irq", 128'(irq), 128'd1);
        rd(BASE + 32'h04, v); chk("to_status", 128'(v), 128'h6);
        rd(BASE + 32'h20, v); chk("to_dout_kept", 128'(v), 128'hF0F0F0F0);
        wr(BASE + 32'h04, 32'h6);
        rd(BASE + 32'h04, v); chk("to_clr", 128'(v), 128'h0);
`else
        repeat (30) @(posedge clk);
        #1 rd(BASE + 32'h04, v); chk("wait_holds", 128'(v), 128'h1);
        pulse_done(R5);
        rd(BASE + 32'h04, v); chk("late_done", 128'(v), 128'h2);
        rd(BASE + 32'h20, v); chk("late_dout", 128'(v), 128'h13579BDF);
        wr(BASE + 32'h04, 32'h6);
`endif

        // asynchronous reset in the middle of an issue
        wr(BASE + 32'h00, 32'h1);
        chk("pre_rst_valid", 128'(core_valid), 128'd1);
        #3 rst_n = 0;
        #1 chk("async_valid_drop", 128'(core_valid), 128'd0);
        chk("async_ack", 128'(ack), 128'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        rd(BASE + 32'h00, v); chk("post_rst_ctrl", 128'(v), 128'h0);
        rd(BASE + 32'h04, v); chk("post_rst_status", 128'(v), 128'h0);
        rd(BASE + 32'h10, v); chk("post_rst_din0", 128'(v), 128'h0);
        rd(BASE + 32'h20, v); chk("post_rst_dout0", 128'(v), 128'h0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
